// File: rtl/mux_stream_arb_pkg.sv
// rtl/mux_stream_arb_pkg.sv - shared constants for the streaming channel arbiter
package mux_pkg;

    localparam logic MODE_RR  = 1'b0;
    localparam logic MODE_SEL = 1'b1;

    localparam int DEF_WIDTH  = 4;
    localparam int DEF_NUM_IN = 4;

endpackage

// File: rtl/mux_stream_arb_if.sv
// rtl/mux_stream_arb_if.sv - producer/consumer handshake bundle for mux_stream_arb
interface mux_stream_arb_if #(
    parameter int WIDTH  = mux_pkg::DEF_WIDTH,
    parameter int NUM_IN = mux_pkg::DEF_NUM_IN,
    parameter int SEL_W  = $clog2(NUM_IN)
);

    logic [NUM_IN*WIDTH-1:0] in_data;
    logic [NUM_IN-1:0]       in_valid;
    logic [NUM_IN-1:0]       in_ready;
    logic                    mode;
    logic [SEL_W-1:0]        select;
    logic [WIDTH-1:0]        out_data;
    logic [SEL_W-1:0]        out_chan;
    logic                    out_valid;
    logic                    out_ready;

    // Master is the environment (producers + consumer), slave is the arbiter.
    modport master (
        output in_data, in_valid, mode, select, out_ready,
        input  in_ready, out_data, out_chan, out_valid
    );

    modport slave (
        input  in_data, in_valid, mode, select, out_ready,
        output in_ready, out_data, out_chan, out_valid
    );

endinterface

// File: rtl/mux_stream_arb_rr_arbiter.sv
// rtl/mux_stream_arb_rr_arbiter.sv - combinational round-robin grant starting after last
module rr_arbiter #(
    parameter int NUM_IN = mux_pkg::DEF_NUM_IN,
    parameter int SEL_W  = $clog2(NUM_IN)
) (
    input  logic [NUM_IN-1:0] req,
    input  logic [SEL_W-1:0]  last,
    output logic [NUM_IN-1:0] grant,
    output logic [SEL_W-1:0]  grant_idx,
    output logic              any_grant
);

    logic [SEL_W-1:0] cand;

    // Visit (last+1)..(last+NUM_IN) modulo NUM_IN; the first requester wins.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any_grant = 1'b0;
        cand      = '0;
        for (int off = 1; off <= NUM_IN; off++) begin
            cand = SEL_W'((int'(last) + off) % NUM_IN);
            if (!any_grant && req[cand]) begin
                grant[cand] = 1'b1;
                grant_idx   = cand;
                any_grant   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mux_stream_arb.sv
// rtl/mux_stream_arb.sv - NUM_IN:1 stream mux, round-robin or manual select, registered output
module mux_stream_arb
    import mux_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int NUM_IN = DEF_NUM_IN,
    parameter int SEL_W  = $clog2(NUM_IN)
) (
    input logic              clk,
    input logic              rst,
    mux_stream_arb_if.slave  bus
);

    logic [NUM_IN-1:0] rr_grant;
    logic [SEL_W-1:0]  rr_idx;
    logic              rr_any;

    logic [NUM_IN-1:0] sel_grant;
    logic              sel_any;

    logic [NUM_IN-1:0] grant;
    logic [SEL_W-1:0]  grant_idx;
    logic              any_grant;
    logic [WIDTH-1:0]  grant_data;

    logic              load;
    logic              xfer;

    logic [SEL_W-1:0]  last_q;
    logic [WIDTH-1:0]  data_q;
    logic [SEL_W-1:0]  chan_q;
    logic              valid_q;

    rr_arbiter #(
        .NUM_IN (NUM_IN),
        .SEL_W  (SEL_W)
    ) u_rr (
        .req       (bus.in_valid),
        .last      (last_q),
        .grant     (rr_grant),
        .grant_idx (rr_idx),
        .any_grant (rr_any)
    );

    // An out-of-range select matches no channel, so it simply never grants.
    always_comb begin
        sel_grant = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            sel_grant[i] = bus.in_valid[i] && (bus.select == SEL_W'(i));
        end
        sel_any = |sel_grant;
    end

    always_comb begin
        if (bus.mode == MODE_SEL) begin
            grant     = sel_grant;
            grant_idx = bus.select;
            any_grant = sel_any;
        end else begin
            grant     = rr_grant;
            grant_idx = rr_idx;
            any_grant = rr_any;
        end
    end

    // Grant is one-hot, so an OR of masked lanes selects the winning word.
    always_comb begin
        grant_data = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            if (grant[i]) begin
                grant_data = grant_data | bus.in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    assign load         = ~valid_q | bus.out_ready;
    assign bus.in_ready = grant & {NUM_IN{load & ~rst}};
    assign xfer         = any_grant & load & ~rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            chan_q  <= '0;
            last_q  <= SEL_W'(NUM_IN - 1);
        end else if (load) begin
            if (xfer) begin
                valid_q <= 1'b1;
                data_q  <= grant_data;
                chan_q  <= grant_idx;
                last_q  <= grant_idx;
            end else begin
                valid_q <= 1'b0;
            end
        end
    end

    assign bus.out_data  = data_q;
    assign bus.out_chan  = chan_q;
    assign bus.out_valid = valid_q;

endmodule

// File: doc/mux_stream_arb.md
Name: mux_stream_arb

Overview:
- Parametrised successor to the team's 4:1 combinational mux.
- Selects one of NUM_IN streaming input channels, each WIDTH bits, onto a single registered output with a valid/ready handshake.
- Two selection modes:
  - Round-robin arbitration.
  - Manual select, matching the legacy mux behaviour but handshaked.
- Sits between multiple producers and a single consumer, for example a shared bus or debug port.

Parameters:
- WIDTH, 4, data bits per channel.
- NUM_IN, 4, number of input channels (2..16).
- SEL_W, $clog2(NUM_IN), width of the select and channel-id fields.

Ports:
- clk  input  1  single clock; everything is sampled on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_data  input  NUM_IN*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
- in_valid  input  NUM_IN  per-channel valid.
- in_ready  output  NUM_IN  per-channel ready; combinational.
- mode  input  1  0 = round-robin, 1 = manual select.
- select  input  SEL_W  channel index, used only when mode = 1.
- out_data  output  WIDTH  registered data.
- out_chan  output  SEL_W  registered index of the source channel.
- out_valid  output  1  registered valid.
- out_ready  input  1  downstream ready.

Behaviour:
- Reset (rst=1 at a clock edge):
  - out_valid=0, out_data=0, out_chan=0.
  - RR pointer last=NUM_IN-1, so channel 0 has first priority.
  - Any held word is discarded.
  - in_ready is 0 while rst=1.
- Load enable: load = ~out_valid | out_ready (single output register, pass-through capable).
- Grant, combinational, at most one-hot:
  - mode=0: the first i with in_valid[i]=1, scanning from (last+1) mod NUM_IN upward with wrap.
  - mode=1: grant[select] = in_valid[select]. If select >= NUM_IN, there is no grant.
- Ready: in_ready[i] = grant[i] & load & ~rst. A transfer on channel i occurs when in_valid[i] & in_ready[i].
- On a transfer:
  - out_data <= channel data, out_chan <= i, out_valid <= 1.
  - last <= i. The pointer updates in both modes, so RR resumes fairly after manual use.
- If load=1 with no grant: out_valid <= 0. out_data and out_chan hold their last value.
- If load=0 (out_valid=1 & out_ready=0): the output register holds, and all in_ready=0.
- Latency and throughput:
  - Input transfer to out_valid is 1 cycle.
  - Sustained throughput is 1 word per cycle when out_ready=1.
- Fairness: with all channels continuously valid in mode 0, grants cycle 0,1,..,NUM_IN-1,0,...
- Mode or select changes take effect in the same cycle's grant. A word already in the output register is unaffected.
- Producers must hold in_valid and in_data stable until accepted. The block does not check this.

Decomposition:
- Shared package mux_pkg:
  - localparams MODE_RR=1'b0, MODE_SEL=1'b1.
  - Default WIDTH and NUM_IN.
- Sub-module rr_arbiter.
  - Inputs: req[NUM_IN], last[SEL_W].
  - Outputs: one-hot grant[NUM_IN], grant_idx[SEL_W], any_grant.
  - Purely combinational; instantiated once.
- Top-level logic: mode mux of the grant, pointer register, output register.

Test Plan:
1. Reset: rst=1 for 2 cycles with all in_valid=1 -> in_ready=0000, out_valid=0, out_data=0, out_chan=0. Release -> first output is channel 0's data, 1 cycle later.
2. RR fairness: in_data=1,3,7,F, all valid, out_ready=1, mode=0 -> out_data sequence 1,3,7,F,1,3 and out_chan 0,1,2,3,0,1, one per cycle.
3. Manual mode (legacy equivalence): mode=1, select stepping 0,1,2,3 every 10 cycles, all valid -> out_data 1,3,7,F respectively, each appearing 1 cycle after the select change.
4. Backpressure: out_ready=0 for 3 cycles while out_valid=1 -> out_data and out_chan stable, in_ready=0000. Raise out_ready -> next grant follows the RR order without skipping.
5. Sparse requests: only in_valid[2] and in_valid[0] set, last=2 -> grant order 0,2,0,2. With no valid inputs and out_ready=1 -> out_valid drops to 0 the next cycle.
6. Reset mid-operation: assert rst while out_valid=1 & out_ready=0 -> the word is dropped, out_valid=0 the next cycle, and the pointer returns so channel 0 wins first after release.
